// File: rtl/inst_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue_pkg : shared widths, NOP encoding and PC alignment helper
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package inst_fetch_queue_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_WIDTH      = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Instructions are word aligned; any set low PC bit flags the entry.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_fifo_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue_fifo_ptr_ctrl : pointers, occupancy and push/pop qualification
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inst_fetch_queue_fifo_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic                       push,
  output logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  assign in_ready  = (r_count != c_depth);
  assign out_valid = (r_count != '0);
  // Flush wins over both ends so nothing from the wrong path survives.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign wr_ptr = r_wr_ptr;
  assign rd_ptr = r_rd_ptr;
  assign count  = r_count;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue : fetch-to-decode FIFO with flush and misaligned-PC tagging
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = INST_ADDR_WIDTH,
  parameter int INST_W = INST_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic                       out_misaligned,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic              r_mis_mem  [DEPTH];

  inst_fetch_queue_fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (w_push),
    .pop       (w_pop),
    .wr_ptr    (w_wr_ptr),
    .rd_ptr    (w_rd_ptr),
    .count     (count)
  );

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[w_wr_ptr]   <= in_pc;
      r_inst_mem[w_wr_ptr] <= in_inst;
      r_mis_mem[w_wr_ptr]  <= pc_misaligned(in_pc[1:0]);
    end
  end

  always_comb begin
    out_pc         = '0;
    out_inst       = INST_W'(NOP_INST);
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_pc         = r_pc_mem[w_rd_ptr];
      out_inst       = r_inst_mem[w_rd_ptr];
      out_misaligned = r_mis_mem[w_rd_ptr];
    end
  end

  logic w_unused_pop;
  assign w_unused_pop = w_pop;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch_queue : table-driven scoreboard bench for inst_fetch_queue
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_misaligned;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          ordy;
    bit          fl;
    int          exp_count;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } ent_t;

  ent_t sb[$];
  vec_t vecs[$];

  inst_fetch_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .INST_W (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_inst        (in_inst),
    .in_ready       (in_ready),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_misaligned (out_misaligned),
    .out_ready      (out_ready),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a falling edge: check current state, drive, advance one cycle.
  task automatic cycle(input bit v, input logic [31:0] pc, input bit ordy,
                       input bit fl, input int exp_count);
    bit do_push;
    bit do_pop;
    ent_t e;
    if (exp_count >= 0) chk("count_table", 32'(count), 32'(exp_count));
    chk("count", 32'(count), 32'(sb.size()));
    chk("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() == 0) begin
      chk("empty_inst", out_inst, NOP_INST);
      chk("empty_pc", out_pc, 32'h0);
      chk("empty_mis", 32'(out_misaligned), 32'h0);
    end
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst_of(pc);
    out_ready = ordy;
    flush     = fl;
    do_pop  = (sb.size() != 0) && ordy && !fl;
    do_push = v && (sb.size() != DEPTH) && !fl;
    if (do_pop) begin
      e = sb.pop_front();
      chk("head_pc", out_pc, e.pc);
      chk("head_inst", out_inst, e.inst);
      chk("head_mis", 32'(out_misaligned), 32'(e.mis));
    end
    if (do_push) begin
      e.pc   = pc;
      e.inst = inst_of(pc);
      e.mis  = (pc[1:0] != 2'b00);
      sb.push_back(e);
    end
    if (fl) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input bit v, input logic [31:0] pc, input bit ordy,
                     input bit fl, input int exp_count);
    vec_t x;
    x.v = v; x.pc = pc; x.ordy = ordy; x.fl = fl; x.exp_count = exp_count;
    vecs.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b0; flush = 1'b0;

    // Idle, then fill to full with a rejected fifth push, then drain.
    add(0, 32'h0, 0, 0, 0); add(0, 32'h0, 0, 0, 0); add(0, 32'h0, 0, 0, 0);
    add(1, 32'h0, 0, 0, 0); add(1, 32'h4, 0, 0, 1);
    add(1, 32'h8, 0, 0, 2); add(1, 32'hC, 0, 0, 3);
    add(1, 32'h10, 1, 0, 4);
    add(0, 32'h0, 1, 0, 3); add(0, 32'h0, 1, 0, 2);
    add(0, 32'h0, 1, 0, 1); add(0, 32'h0, 1, 0, 0);
    // Streaming at occupancy 2 across pointer wrap.
    add(1, 32'h100, 0, 0, 0); add(1, 32'h104, 0, 0, 1);
    for (int i = 0; i < 8; i++) add(1, 32'h108 + 32'(i * 4), 1, 0, 2);
    add(0, 32'h0, 0, 0, 2);
    // Flush at occupancy 3 with a concurrent push and pop.
    add(1, 32'h128, 0, 0, 2); add(1, 32'h20, 1, 1, 3);
    add(0, 32'h0, 0, 0, 0); add(0, 32'h0, 1, 0, 0);
    // Misaligned entry followed by an aligned one.
    add(1, 32'h6, 0, 0, 0); add(1, 32'h8, 0, 0, 1);
    add(0, 32'h0, 1, 0, 2); add(0, 32'h0, 1, 0, 1); add(0, 32'h0, 0, 0, 0);

    #3;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_inst", out_inst, 32'h0000_0013);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) cycle(vecs[i].v, vecs[i].pc, vecs[i].ordy, vecs[i].fl, vecs[i].exp_count);

    // Asynchronous reset in the middle of a cycle at occupancy 2.
    cycle(1, 32'h30, 0, 0, 0);
    cycle(1, 32'h34, 0, 0, 1);
    chk("pre_arst_count", 32'(count), 32'h2);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out_inst", out_inst, 32'h0000_0013);
    sb.delete();
    #1 reset = 1'b0;
    cycle(1, 32'h40, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 1);
    cycle(0, 32'h0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Small FIFO between the PC/instruction-memory fetch stage and the decode stage.
- Decouples fetch from decode stalls and back-pressures PC advance when full.
- Discards all queued instructions on a taken branch/jump (flush).
- Tags each entry with a misaligned-PC flag so decode can raise an exception.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- ADDR_W, `INST_ADDR_WIDTH (32), PC width.
- INST_W, `INST_WIDTH (32), instruction width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch stage presents a PC/instruction pair.
- in_pc  input  ADDR_W  PC of the fetched instruction.
- in_inst  input  INST_W  instruction word from instruction memory.
- in_ready  output  1  queue accepts a push this cycle; fetch holds the PC when low.
- flush  input  1  taken branch/jump; discards all entries.
- out_valid  output  1  head entry available to decode.
- out_pc  output  ADDR_W  PC of the head entry.
- out_inst  output  INST_W  instruction of the head entry; NOP when empty.
- out_misaligned  output  1  head entry PC has bits [1:0] != 0.
- out_ready  input  1  decode consumes the head entry this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy, for debug and verification.

Behaviour:
- Reset, asynchronous:
  - wr_ptr = rd_ptr = 0 and count = 0.
  - out_valid = 0, out_pc = 0, out_inst = `NOP_INST (32'h00000013), out_misaligned = 0.
  - Storage contents are don't-care.
- Combinational status:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
- Push: push = in_valid && in_ready && !flush. It writes {in_pc, in_inst, in_pc[1:0]!=0} at wr_ptr, then wr_ptr increments.
- Pop: pop = out_valid && out_ready && !flush. rd_ptr increments.
- Count update: count' = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Full with out_ready high:
  - in_ready is still 0; no same-cycle push-through.
  - The freed slot is pushable from the next cycle.
- Empty with in_valid:
  - Data appears on the outputs the cycle after the push edge; no bypass.
  - Latency from push to out_valid is 1 cycle.
- Head outputs are combinational reads of the entry at rd_ptr. When count == 0, out_inst shows NOP, out_pc shows 0 and out_misaligned shows 0.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Flush:
  - Synchronous and highest priority.
  - At the edge: wr_ptr = rd_ptr = 0 and count = 0.
  - Any push or pop in the flush cycle is discarded.
  - out_valid is 0 in the following cycle.
  - The fetch stage supplies the redirected PC from the next cycle.
- Reset mid-operation (asynchronous assertion) returns immediately to the reset state. The first push is accepted at the first rising edge after reset deasserts.
- Misalignment is a flag only. The queue never drops or modifies misaligned entries.
- Entry contents do not change except on push, so the head is stable while out_ready is low.

Decomposition:
- const.v gains `INST_WIDTH (32) and `NOP_INST (32'h00000013).
- const.v reuses the existing `INST_ADDR_WIDTH.
- The natural sub-module is fifo_ptr_ctrl: pointers, count, push/pop/flush qualification and full/empty.
- The top level holds the entry storage array and the NOP/zero output muxing.

Test Plan:
- Reset then idle: check out_valid=0, out_inst=32'h00000013, in_ready=1, count=0; release reset, 3 idle cycles, all unchanged.
- Fill and drain: push PCs 0x0, 0x4, 0x8, 0xC with out_ready=0.
  - Expect count=4 and in_ready=0, and a 5th in_valid ignored.
  - Then out_ready=1: PCs pop in order 0x0→0xC, then out_valid=0.
- Simultaneous push/pop at count=2 (DEPTH=4): count stays 2; ordering preserved across 8 cycles of streaming, which exercises pointer wrap past 3→0.
- Flush at count=3 with in_valid=1 (pc 0x20) and out_ready=1: the next cycle shows count=0 and out_valid=0; the 0x20 entry does not appear afterwards.
- Misaligned push: in_pc=0x00000006 → out_misaligned=1 with out_pc=0x6; the following entry 0x8 shows out_misaligned=0.
- Asynchronous reset asserted mid-cycle at count=2: count=0 and out_valid=0 before the next clock edge; first push accepted on the first edge after deassertion.
